// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result_tx frame transmitter.
package result_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SEND     = 3'd2,
    WAIT_LOW = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int         FRAME_LEN_BASE   = 6;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Payload byte at position idx of a frame (header, result, weights).
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  hdr,
                                            input logic [22:0] fin,
                                            input logic [15:0] wts);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = fin[7:0];
      3'd2:    b = fin[15:8];
      3'd3:    b = {1'b0, fin[22:16]};
      3'd4:    b = wts[7:0];
      3'd5:    b = wts[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ack_sync_edge.sv
// Two-flop synchroniser for the host ack pin plus rise/fall pulse detection
// on the synchronised level.
module ack_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ack_i,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchroniser stages, [2] previous synchronised level
  logic [2:0] sh_q, sh_d;

  // Shift the raw pin into the chain.
  always_comb begin
    sh_d = {sh_q[1:0], ack_i};
  end

  // Chain registers, cleared by the async active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/result_tx.sv
// Training-result frame transmitter: snapshots result and weights on start,
// then sends the frame byte by byte over a 4-phase valid/ack handshake.
// Optional feature macro: RESULT_TX_CHECKSUM_EN appends an XOR checksum byte.
//
// state    | meaning
// IDLE     | waiting for start_i
// LOAD     | clear error/index, present header byte
// SEND     | valid_o high, waiting for a fresh ack rise
// WAIT_LOW | byte taken, waiting for ack to fall
// DONE     | one-cycle done_o pulse
module result_tx
  import result_tx_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE       = HDR_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1023,
  parameter int         TO_W           = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [22:0] final_i,
  input  logic [15:0] weights_i,
  input  logic        ack_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef RESULT_TX_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [2:0]      LAST_IDX = 3'(FRAME_LEN - 1);
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [22:0]       fin_q, fin_d;
  logic [15:0]       wts_q, wts_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic       ack_rise, ack_fall;
  logic       timeout_hit;
  logic [2:0] idx_nxt;
  logic [7:0] nxt_byte;

  ack_sync_edge u_ack_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ack_i  (ack_i),
    .rise_o (ack_rise),
    .fall_o (ack_fall)
  );

  assign timeout_hit = TO_EN && (to_cnt_q == TO_LAST);

  // Next-state, snapshot, byte selection and timeout counting.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = err_q;
    fin_d    = fin_q;
    wts_d    = wts_q;
    to_cnt_d = '0;
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    idx_nxt  = idx_q + 3'd1;
    nxt_byte = frame_byte(idx_nxt, HDR_BYTE, fin_q, wts_q);
`ifdef RESULT_TX_CHECKSUM_EN
    // csum_q already covers every payload byte once the last one is acked
    if (idx_nxt == 3'(FRAME_LEN_BASE)) nxt_byte = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          fin_d   = final_i;
          wts_d   = weights_i;
        end
      end
      LOAD: begin
        err_d   = 1'b0;
        idx_d   = 3'd0;
        byte_d  = HDR_BYTE;
        valid_d = 1'b1;
        state_d = SEND;
`ifdef RESULT_TX_CHECKSUM_EN
        csum_d  = 8'h00;
`endif
      end
      SEND: begin
        if (ack_rise) begin
          valid_d = 1'b0;
          state_d = WAIT_LOW;
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d  = csum_q ^ byte_q;
`endif
        end else if (timeout_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_LOW: begin
        if (ack_fall) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_nxt;
            byte_d  = nxt_byte;
            valid_d = 1'b1;
            state_d = SEND;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fin_q    <= '0;
      wts_q    <= '0;
      to_cnt_q <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fin_q    <= fin_d;
      wts_q    <= wts_d;
      to_cnt_q <= to_cnt_d;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule
